// File: rtl/rv_scoreboard.sv
// rv_scoreboard: register-pending scoreboard for an in-order RISC-V pipeline.
// Tracks destinations of outstanding long-latency (mul/div) ops and raises
// stall/bubble on RAW, WAW, load-use and structural hazards at decode.
// Optional feature macro: SCOREBOARD_PERF_EN adds a saturating stall-cycle
// counter on output stall_cnt_o.
module rv_scoreboard #(
    parameter int MAX_OUT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ID_valid_i,
    input  logic [4:0]  ID_rs1_i,
    input  logic [4:0]  ID_rs2_i,
    input  logic        ID_use_rs1_i,
    input  logic        ID_use_rs2_i,
    input  logic [4:0]  ID_rd_i,
    input  logic        ID_reg_write_i,
    input  logic        ID_long_i,
    input  logic        EX_mem_read_i,
    input  logic [4:0]  EX_rd_i,
    input  logic        long_done_i,
    input  logic [4:0]  long_rd_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        bubble_o,
    output logic [31:0] pending_o,
    output logic        busy_o,
`ifdef SCOREBOARD_PERF_EN
    output logic [31:0] stall_cnt_o,
`endif
    output logic        err_o
);

    localparam logic [2:0] MaxOutC = 3'(MAX_OUT);

    logic [31:0] pending_q, pending_d;
    logic [2:0]  count_q, count_d;
    logic        err_q, err_d;

    logic rawHaz, wawHaz, loadUseHaz, structHaz;
    logic issue, doneOk, doneBad;

    // Hazard detection from decode inputs and registered scoreboard state only
    always_comb begin
        rawHaz     = (ID_use_rs1_i && (ID_rs1_i != 5'd0) && pending_q[ID_rs1_i]) ||
                     (ID_use_rs2_i && (ID_rs2_i != 5'd0) && pending_q[ID_rs2_i]);
        wawHaz     = ID_reg_write_i && (ID_rd_i != 5'd0) && pending_q[ID_rd_i];
        loadUseHaz = EX_mem_read_i && (EX_rd_i != 5'd0) &&
                     ((ID_use_rs1_i && (ID_rs1_i == EX_rd_i)) ||
                      (ID_use_rs2_i && (ID_rs2_i == EX_rd_i)));
        structHaz  = ID_long_i && (count_q == MaxOutC);
        stall_o    = ID_valid_i && !flush_i && (rawHaz || wawHaz || loadUseHaz || structHaz);
        bubble_o   = stall_o;
    end

    // Classify this cycle's issue and completion events
    always_comb begin
        issue   = ID_valid_i && !stall_o && !flush_i && ID_long_i;
        // A completion is legitimate only if something is outstanding and,
        // for a real destination, that register is actually marked pending.
        doneBad = long_done_i &&
                  ((count_q == 3'd0) || ((long_rd_i != 5'd0) && !pending_q[long_rd_i]));
        doneOk  = long_done_i && !doneBad;
    end

    // Next-state for pending vector, outstanding count and sticky error
    always_comb begin
        pending_d = pending_q;
        count_d   = count_q;
        err_d     = err_q;
        if (doneOk && (long_rd_i != 5'd0)) begin
            pending_d[long_rd_i] = 1'b0;
        end
        // Issue to a still-pending rd is blocked by WAW, so set after clear is safe
        if (issue && ID_reg_write_i && (ID_rd_i != 5'd0)) begin
            pending_d[ID_rd_i] = 1'b1;
        end
        pending_d[0] = 1'b0;
        case ({issue, doneOk})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
        if (doneBad) begin
            err_d = 1'b1;
        end
    end

    // Scoreboard state registers; reset discards all in-flight tracking
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_q <= 32'd0;
            count_q   <= 3'd0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            count_q   <= count_d;
            err_q     <= err_d;
        end
    end

    assign pending_o = pending_q;
    assign busy_o    = (count_q != 3'd0);
    assign err_o     = err_q;

`ifdef SCOREBOARD_PERF_EN
    logic [31:0] stall_cnt_q;

    // Count stalled cycles, sticking at all-ones rather than wrapping
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= 32'd0;
        end else if (stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_rv_scoreboard.sv
// tb_rv_scoreboard: directed-vector scoreboard bench for rv_scoreboard.
// Stimulus pushes hand-computed expectations per cycle; a negedge monitor
// pops and compares them against the DUT outputs.
module tb_rv_scoreboard;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ID_valid_i;
    logic [4:0]  ID_rs1_i, ID_rs2_i, ID_rd_i, EX_rd_i, long_rd_i;
    logic        ID_use_rs1_i, ID_use_rs2_i, ID_reg_write_i, ID_long_i;
    logic        EX_mem_read_i, long_done_i, flush_i;
    logic        stall_o, bubble_o, busy_o, err_o;
    logic [31:0] pending_o;
`ifdef SCOREBOARD_PERF_EN
    logic [31:0] stall_cnt_o;
`endif

    typedef struct {
        logic [127:0] nm;
        logic         stall;
        logic [31:0]  pend;
        logic         busy;
        logic         err;
        logic [31:0]  cnt;
    } exp_t;

    exp_t expQ[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic [31:0] expCnt = 32'd0;

    rv_scoreboard #(.MAX_OUT(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ID_valid_i(ID_valid_i), .ID_rs1_i(ID_rs1_i), .ID_rs2_i(ID_rs2_i),
        .ID_use_rs1_i(ID_use_rs1_i), .ID_use_rs2_i(ID_use_rs2_i),
        .ID_rd_i(ID_rd_i), .ID_reg_write_i(ID_reg_write_i), .ID_long_i(ID_long_i),
        .EX_mem_read_i(EX_mem_read_i), .EX_rd_i(EX_rd_i),
        .long_done_i(long_done_i), .long_rd_i(long_rd_i), .flush_i(flush_i),
        .stall_o(stall_o), .bubble_o(bubble_o), .pending_o(pending_o),
        .busy_o(busy_o),
`ifdef SCOREBOARD_PERF_EN
        .stall_cnt_o(stall_cnt_o),
`endif
        .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    // Compare one output field and record a miscompare
    task automatic checkOutput(input logic [127:0] nm, input string fld,
                               input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s.%s got %h expected %h", nm, fld, act, exp);
        end
    endtask

    // Monitor: DUT outputs are valid every cycle; compare mid-cycle
    always @(negedge clk_i) begin
        if (expQ.size() != 0) begin
            exp_t e;
            e = expQ.pop_front();
            vectors++;
            checkOutput(e.nm, "stall",   {31'd0, stall_o},  {31'd0, e.stall});
            checkOutput(e.nm, "bubble",  {31'd0, bubble_o}, {31'd0, e.stall});
            checkOutput(e.nm, "pending", pending_o,         e.pend);
            checkOutput(e.nm, "busy",    {31'd0, busy_o},   {31'd0, e.busy});
            checkOutput(e.nm, "err",     {31'd0, err_o},    {31'd0, e.err});
`ifdef SCOREBOARD_PERF_EN
            checkOutput(e.nm, "stallcnt", stall_cnt_o, e.cnt);
`endif
        end
    end

    // Drive nothing active on the decode/EX/long-unit side
    task automatic idleInputs();
        ID_valid_i = 0; ID_rs1_i = 0; ID_rs2_i = 0; ID_use_rs1_i = 0; ID_use_rs2_i = 0;
        ID_rd_i = 0; ID_reg_write_i = 0; ID_long_i = 0;
        EX_mem_read_i = 0; EX_rd_i = 0; long_done_i = 0; long_rd_i = 0; flush_i = 0;
    endtask

    task automatic setId(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic rw, input logic lg);
        ID_valid_i = v; ID_rs1_i = rs1; ID_rs2_i = rs2; ID_use_rs1_i = u1;
        ID_use_rs2_i = u2; ID_rd_i = rd; ID_reg_write_i = rw; ID_long_i = lg;
    endtask

    // Push the expectation for the current cycle, then advance one cycle
    task automatic applyStimulus(input logic [127:0] nm, input logic eStall,
                                 input logic [31:0] ePend, input logic eBusy, input logic eErr);
        exp_t e;
        if (rst_i) expCnt = 32'd0;
        e.nm = nm; e.stall = eStall; e.pend = ePend; e.busy = eBusy; e.err = eErr; e.cnt = expCnt;
        expQ.push_back(e);
        if (!rst_i && eStall && expCnt != 32'hFFFF_FFFF) expCnt = expCnt + 32'd1;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_i = 1'b1;
        idleInputs();
        @(posedge clk_i);
        #1;
        applyStimulus("rst_idle", 0, 32'h0, 0, 0);
        setId(1, 5'd5, 5'd0, 1, 0, 5'd0, 0, 0); EX_mem_read_i = 1; EX_rd_i = 5'd5;
        applyStimulus("rst_ldu", 1, 32'h0, 0, 0);
        rst_i = 1'b0;

        // load x5 in EX, add x6,x5,x1 in ID
        setId(1, 5'd5, 5'd1, 1, 1, 5'd6, 1, 0); EX_mem_read_i = 1; EX_rd_i = 5'd5;
        applyStimulus("ldu_stall", 1, 32'h0, 0, 0);
        EX_mem_read_i = 0;
        applyStimulus("ldu_go", 0, 32'h0, 0, 0);
        setId(1, 5'd0, 5'd0, 1, 1, 5'd6, 1, 0); EX_mem_read_i = 1; EX_rd_i = 5'd0;
        applyStimulus("x0_ldu", 0, 32'h0, 0, 0);
        idleInputs();

        // div x7, then add x8,x7,x0 waits for completion
        setId(1, 5'd1, 5'd2, 1, 1, 5'd7, 1, 1);
        applyStimulus("div_x7", 0, 32'h0, 0, 0);
        setId(1, 5'd7, 5'd0, 1, 1, 5'd8, 1, 0);
        applyStimulus("add_x7_stall", 1, 32'h80, 1, 0);
        long_done_i = 1; long_rd_i = 5'd7;
        applyStimulus("done7_stall", 1, 32'h80, 1, 0);
        long_done_i = 0; long_rd_i = 5'd0;
        applyStimulus("add_x7_go", 0, 32'h0, 0, 0);

        // fill to MAX_OUT, fifth long op waits for a slot
        setId(1, 5'd0, 5'd0, 0, 0, 5'd1, 1, 1);
        applyStimulus("mul_x1", 0, 32'h0, 0, 0);
        ID_rd_i = 5'd2;
        applyStimulus("mul_x2", 0, 32'h2, 1, 0);
        ID_rd_i = 5'd3;
        applyStimulus("mul_x3", 0, 32'h6, 1, 0);
        ID_rd_i = 5'd4;
        applyStimulus("mul_x4", 0, 32'hE, 1, 0);
        ID_rd_i = 5'd10;
        applyStimulus("mul5_struct", 1, 32'h1E, 1, 0);
        long_done_i = 1; long_rd_i = 5'd2;
        applyStimulus("mul5_done2", 1, 32'h1E, 1, 0);
        long_done_i = 0; long_rd_i = 5'd0;
        applyStimulus("mul5_issue", 0, 32'h1A, 1, 0);
        setId(1, 5'd0, 5'd0, 0, 0, 5'd1, 1, 0);
        applyStimulus("waw_x1", 1, 32'h41A, 1, 0);
        idleInputs(); long_done_i = 1; long_rd_i = 5'd1;
        applyStimulus("done1", 0, 32'h41A, 1, 0);
        idleInputs(); setId(1, 5'd0, 5'd0, 0, 0, 5'd0, 1, 1);
        applyStimulus("long_x0", 0, 32'h418, 1, 0);

        // spurious completion, count must stay at four
        idleInputs(); long_done_i = 1; long_rd_i = 5'd9;
        applyStimulus("bad_done9", 0, 32'h418, 1, 0);
        idleInputs(); setId(1, 5'd0, 5'd0, 0, 0, 5'd11, 1, 1);
        applyStimulus("struct_after_err", 1, 32'h418, 1, 1);
        idleInputs(); setId(1, 5'd3, 5'd0, 1, 0, 5'd0, 0, 0); flush_i = 1;
        applyStimulus("flush_haz", 0, 32'h418, 1, 1);
        flush_i = 0;
        applyStimulus("no_flush_haz", 1, 32'h418, 1, 1);

        // drain remaining ops: x0, x3, x4, x10
        idleInputs(); long_done_i = 1; long_rd_i = 5'd0;
        applyStimulus("done_x0", 0, 32'h418, 1, 1);
        long_rd_i = 5'd3;
        applyStimulus("done3", 0, 32'h418, 1, 1);
        long_rd_i = 5'd4;
        applyStimulus("done4", 0, 32'h410, 1, 1);
        long_rd_i = 5'd10;
        applyStimulus("done10", 0, 32'h400, 1, 1);
        idleInputs();
        applyStimulus("drained", 0, 32'h0, 0, 1);

        // reset mid-operation, then a late completion
        setId(1, 5'd0, 5'd0, 0, 0, 5'd12, 1, 1);
        applyStimulus("mul_x12", 0, 32'h0, 0, 1);
        idleInputs(); rst_i = 1'b1;
        applyStimulus("rst_mid", 0, 32'h0, 0, 0);
        rst_i = 1'b0; long_done_i = 1; long_rd_i = 5'd12;
        applyStimulus("late_done12", 0, 32'h0, 0, 0);
        idleInputs();
        applyStimulus("late_err", 0, 32'h0, 0, 1);

        for (int i = 0; i < 5 && expQ.size() != 0; i++) @(negedge clk_i);
        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain got %0d pending expected 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
